// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller.
//   sb_entry_t : one scoreboard slot (EX, MEM or WB) holding hazard-relevant control fields
//   fwd_sel_e  : EX operand source select encoding
//   REG_X0     : hard-wired zero register index, never a hazard or forwarding source
// The scoreboard index width is fixed at SB_ADDR_W; hazard_unit narrows or widens its
// REG_ADDR_W inputs to this width, so the two must agree for correct matching.
package hazard_pkg;

    localparam int unsigned SB_ADDR_W = 5;

    localparam logic [SB_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic                 has_rs1;
        logic                 has_rs2;
        logic [SB_ADDR_W-1:0] rs1;
        logic [SB_ADDR_W-1:0] rs2;
        logic [SB_ADDR_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // An entry produces a register result that a younger instruction may depend on.
    function automatic logic is_writer(sb_entry_t e);
        return e.valid & e.reg_write & (e.rd != REG_X0);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one source operand against one scoreboard entry.
// Ports:
//   has_rs : the source operand is actually read
//   rs     : source register index
//   entry  : scoreboard entry to compare against
//   match  : entry is a writer of a non-x0 register equal to rs
module hazard_match
    import hazard_pkg::*;
(
    input  logic                 has_rs,
    input  logic [SB_ADDR_W-1:0] rs,
    input  sb_entry_t            entry,
    output logic                 match
);

    // Source-side fields of the entry are irrelevant when it acts as a producer.
    logic entry_unused;
    assign entry_unused = ^{entry.has_rs1, entry.has_rs2, entry.rs1, entry.rs2, entry.mem_read};

    always_comb begin
        match = has_rs & is_writer(entry) & (entry.rd == rs);
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: data/control hazard controller sitting beside the ID/EX pipeline register.
// Tracks EX/MEM/WB destinations in a scoreboard shift pipeline and produces stall, flush,
// bubble and EX operand forwarding selects.
// Build option: define HAZARD_FORWARD_EN when the forwarding datapath exists; only load-use
// stalls then, and fwd_*_sel are driven. Without it, any EX/MEM producer stalls and the
// selects stay at FWD_REG.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   id_*                      : decoded fields of the instruction currently in ID
//   ex_branch_taken           : EX redirects the PC this cycle
//   stall                     : hold PC and IF/ID
//   flush_if_id               : clear IF/ID to a bubble
//   bubble_id_ex              : load zero controls into ID/EX
//   fwd_a_sel / fwd_b_sel     : EX operand A/B source (00 regfile, 01 MEM, 10 WB)
//   stall_cycles              : saturating count of cycles with stall asserted
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_has_rs1,
    input  logic                  id_has_rs2,
    input  logic                  id_has_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  bubble_id_ex,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cycles
);

    sb_entry_t        ex_q, ex_d;
    sb_entry_t        mem_q, mem_d;
    sb_entry_t        wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sb_entry_t                   id_entry;
    logic [1:0]                  id_uses;
    logic [1:0][SB_ADDR_W-1:0]   id_src;
    logic [1:0]                  id_hit_ex;
    logic                        hazard;

    always_comb begin
        id_entry           = SB_EMPTY;
        id_entry.valid     = id_valid;
        id_entry.has_rs1   = id_has_rs1;
        id_entry.has_rs2   = id_has_rs2;
        id_entry.rs1       = SB_ADDR_W'(id_rs1);
        id_entry.rs2       = SB_ADDR_W'(id_rs2);
        id_entry.rd        = SB_ADDR_W'(id_rd);
        // An instruction without an rd field cannot produce a result.
        id_entry.reg_write = id_reg_write & id_has_rd;
        id_entry.mem_read  = id_mem_read;
    end

    assign id_uses = {id_valid & id_has_rs2, id_valid & id_has_rs1};
    assign id_src  = {id_entry.rs2, id_entry.rs1};

    for (genvar s = 0; s < 2; s++) begin : g_id_ex
        hazard_match u_id_ex (
            .has_rs (id_uses[s]),
            .rs     (id_src[s]),
            .entry  (ex_q),
            .match  (id_hit_ex[s])
        );
    end

`ifdef HAZARD_FORWARD_EN
    logic [1:0]                ex_uses;
    logic [1:0][SB_ADDR_W-1:0] ex_src;
    logic [1:0]                ex_hit_mem;
    logic [1:0]                ex_hit_wb;
    fwd_sel_e                  fwd_a;
    fwd_sel_e                  fwd_b;

    assign ex_uses = {ex_q.valid & ex_q.has_rs2, ex_q.valid & ex_q.has_rs1};
    assign ex_src  = {ex_q.rs2, ex_q.rs1};

    for (genvar s = 0; s < 2; s++) begin : g_ex_fwd
        hazard_match u_ex_mem (
            .has_rs (ex_uses[s]),
            .rs     (ex_src[s]),
            .entry  (mem_q),
            .match  (ex_hit_mem[s])
        );
        hazard_match u_ex_wb (
            .has_rs (ex_uses[s]),
            .rs     (ex_src[s]),
            .entry  (wb_q),
            .match  (ex_hit_wb[s])
        );
    end

    // Only a load in EX cannot be forwarded in time; everything else reaches EX via bypass.
    assign hazard = (|id_hit_ex) & ex_q.mem_read;

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (ex_hit_mem[0]) begin
            fwd_a = FWD_MEM;
        end else if (ex_hit_wb[0]) begin
            fwd_a = FWD_WB;
        end
        if (ex_hit_mem[1]) begin
            fwd_b = FWD_MEM;
        end else if (ex_hit_wb[1]) begin
            fwd_b = FWD_WB;
        end
    end

    assign fwd_a_sel = fwd_a;
    assign fwd_b_sel = fwd_b;
`else
    logic [1:0] id_hit_mem;

    for (genvar s = 0; s < 2; s++) begin : g_id_mem
        hazard_match u_id_mem (
            .has_rs (id_uses[s]),
            .rs     (id_src[s]),
            .entry  (mem_q),
            .match  (id_hit_mem[s])
        );
    end

    // The write-through regfile covers WB, so only EX and MEM producers block ID.
    assign hazard = (|id_hit_ex) | (|id_hit_mem);

    assign fwd_a_sel = FWD_REG;
    assign fwd_b_sel = FWD_REG;

    logic wb_unused;
    assign wb_unused = ^wb_q;
`endif

    // Redirect beats any data hazard: the ID instruction is discarded, so there is nothing to hold.
    always_comb begin
        stall        = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        if (!rst) begin
            if (ex_branch_taken) begin
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (hazard) begin
                stall        = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = (id_valid && !bubble_id_ex) ? id_entry : SB_EMPTY;
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit (CNT_W = 4).
// Expected values adapt to whether HAZARD_FORWARD_EN is defined for the build.
module tb_hazard_unit;

`ifdef HAZARD_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif
    localparam int unsigned CntMax = 15;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic       id_has_rs1;
    logic       id_has_rs2;
    logic       id_has_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_branch_taken;
    logic       stall;
    logic       flush_if_id;
    logic       bubble_id_ex;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic [3:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    hazard_unit #(
        .REG_ADDR_W (5),
        .CNT_W      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_has_rs1      (id_has_rs1),
        .id_has_rs2      (id_has_rs2),
        .id_has_rd       (id_has_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush_if_id     (flush_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_hz(input string tag, input bit s, input bit f, input bit b);
        check_eq({tag, "_stall"}, 32'(stall), 32'(s));
        check_eq({tag, "_flush"}, 32'(flush_if_id), 32'(f));
        check_eq({tag, "_bubble"}, 32'(bubble_id_ex), 32'(b));
    endtask

    // Expected counter advances on each cycle where the bench expects a stall at the edge.
    task automatic tick(input bit s);
        if (s && exp_cnt != CntMax) exp_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input bit v, input bit h1, input bit h2, input bit hd,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input bit rw, input bit mr);
        id_valid     = v;
        id_has_rs1   = h1;
        id_has_rs2   = h2;
        id_has_rd    = hd;
        id_rs1       = r1;
        id_rs2       = r2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic id_idle();
        set_id(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic id_load(input logic [4:0] rd, input logic [4:0] base);
        set_id(1'b1, 1'b1, 1'b0, 1'b1, base, 5'd0, rd, 1'b1, 1'b1);
    endtask

    task automatic id_alu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        set_id(1'b1, 1'b1, 1'b1, 1'b1, r1, r2, rd, 1'b1, 1'b0);
    endtask

    task automatic drain();
        id_idle();
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        rst             = 1'b1;
        ex_branch_taken = 1'b0;
        id_idle();
        step();
        step();
        rst = 1'b0;
        settle();
        check_hz("init", 1'b0, 1'b0, 1'b0);
        check_eq("init_cnt", 32'(stall_cycles), 32'd0);

        // 1: reset while a load-use stall is active
        id_load(5'd5, 5'd1);
        step();
        id_alu(5'd6, 5'd5, 5'd7);
        settle();
        check_eq("t1_pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        settle();
        check_hz("t1_post", 1'b0, 1'b0, 1'b0);
        check_eq("t1_fwd_a", 32'(fwd_a_sel), 32'd0);
        check_eq("t1_fwd_b", 32'(fwd_b_sel), 32'd0);
        check_eq("t1_cnt", 32'(stall_cycles), 32'd0);
        drain();

        // 2: lw x5 ; add x6,x5,x7
        id_load(5'd5, 5'd1);
        settle();
        check_eq("t2_lw_stall", 32'(stall), 32'd0);
        step();
        id_alu(5'd6, 5'd5, 5'd7);
        settle();
        check_hz("t2_b", 1'b1, 1'b0, 1'b1);
        tick(1'b1);
        step();
        settle();
        check_eq("t2_c_stall", 32'(stall), 32'(!Fwd));
        tick(!Fwd);
        step();
        settle();
        check_eq("t2_d_stall", 32'(stall), 32'd0);
        check_eq("t2_d_fwd_a", 32'(fwd_a_sel), Fwd ? 32'd2 : 32'd0);
        check_eq("t2_d_fwd_b", 32'(fwd_b_sel), 32'd0);
        tick(1'b0);
        step();
        check_eq("t2_cnt", 32'(stall_cycles), 32'(exp_cnt));
        drain();

        // 3: add x5 ; sub x8,x1,x5
        id_alu(5'd5, 5'd2, 5'd3);
        step();
        id_alu(5'd8, 5'd1, 5'd5);
        settle();
        check_eq("t3_b_stall", 32'(stall), 32'(!Fwd));
        tick(!Fwd);
        step();
        settle();
        check_eq("t3_c_stall", 32'(stall), 32'(!Fwd));
        check_eq("t3_c_fwd_b", 32'(fwd_b_sel), Fwd ? 32'd1 : 32'd0);
        check_eq("t3_c_fwd_a", 32'(fwd_a_sel), 32'd0);
        tick(!Fwd);
        step();
        settle();
        check_eq("t3_d_stall", 32'(stall), 32'd0);
        step();
        check_eq("t3_cnt", 32'(stall_cycles), 32'(exp_cnt));
        drain();

        // 4: lw x0 ; reader of x0 on both sources
        id_load(5'd0, 5'd1);
        step();
        id_alu(5'd9, 5'd0, 5'd0);
        settle();
        check_hz("t4_b", 1'b0, 1'b0, 1'b0);
        step();
        id_idle();
        settle();
        check_eq("t4_fwd_a", 32'(fwd_a_sel), 32'd0);
        check_eq("t4_fwd_b", 32'(fwd_b_sel), 32'd0);
        drain();

        // 5: load-use coinciding with a taken branch
        id_load(5'd9, 5'd1);
        step();
        id_alu(5'd10, 5'd9, 5'd9);
        ex_branch_taken = 1'b1;
        settle();
        check_hz("t5", 1'b0, 1'b1, 1'b1);
        step();
        ex_branch_taken = 1'b0;
        id_idle();
        settle();
        check_eq("t5_cnt", 32'(stall_cycles), 32'(exp_cnt));
        drain();

        // 6: 20 load-use pairs drive the 4-bit counter into saturation
        for (int p = 0; p < 20; p++) begin
            id_load(5'd5, 5'd1);
            step();
            for (int k = 0; k < 3; k++) begin
                bit e;
                e = (k == 0) ? 1'b1 : ((k == 1) ? !Fwd : 1'b0);
                id_alu(5'd6, 5'd5, 5'd7);
                settle();
                check_eq($sformatf("t6_p%0d_k%0d_stall", p, k), 32'(stall), 32'(e));
                tick(e);
                step();
            end
            check_eq($sformatf("t6_p%0d_cnt", p), 32'(stall_cycles), 32'(exp_cnt));
        end
        check_eq("t6_sat", 32'(stall_cycles), 32'd15);
        drain();
        check_eq("t6_hold", 32'(stall_cycles), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
